// File: rtl/mem_initiator.sv
// mem_initiator: one-at-a-time command initiator for the
// 8x8 memory responder, with read/write completion counters.
module mem_initiator #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_enable,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(RD_LAT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              wr_q, wr_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  // next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    wr_d          = wr_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    mem_enable_d  = 1'b0;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          state_d       = ISSUE;
          req_ready_d   = 1'b0;
          wr_d          = req_write;
          mem_enable_d  = 1'b1;
          mem_rd_wr_d   = ~req_write;
          mem_addr_d    = req_addr;
          mem_wr_data_d = req_write ? req_wdata : '0;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = WAIT;
          wcnt_d  = LAT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = mem_rd_data;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          if (wr_q) begin
            wr_cnt_d = wr_cnt_q + ONE;
          end else begin
            rd_cnt_d = rd_cnt_q + ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      wr_q          <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_enable_q  <= 1'b0;
      mem_rd_wr_q   <= 1'b1;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      wr_q          <= wr_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_enable_q  <= mem_enable_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_enable  = mem_enable_q;
  assign mem_rd_wr   = mem_rd_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign rd_cnt      = rd_cnt_q;
  assign wr_cnt      = wr_cnt_q;

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: scoreboard bench with a responder model
// and a transaction-level reference of memory and counters.
module tb_mem_initiator;

  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          mem_enable;
  logic          mem_rd_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;

  always #5 clk = ~clk;

  mem_initiator #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .RD_LAT(LAT),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .mem_enable (mem_enable),
    .mem_rd_wr  (mem_rd_wr),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  // responder: resets to 0xFF, two-edge read pipeline,
  // rd_data is garbage outside the one valid cycle
  logic [DW-1:0] mem [8];
  logic [DW-1:0] stg;
  logic          stg_v;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '1;
      stg         <= '0;
      stg_v       <= 1'b0;
      mem_rd_data <= '0;
    end else begin
      stg_v <= mem_enable && mem_rd_wr;
      if (mem_enable && !mem_rd_wr) mem[mem_addr] <= mem_wr_data;
      if (mem_enable && mem_rd_wr) stg <= mem[mem_addr];
      mem_rd_data <= stg_v ? stg : DW'($urandom);
    end
  end

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    int            acc;
  } txn_t;

  txn_t          q[$];
  logic [DW-1:0] ref_mem [8];
  logic [CW-1:0] exp_rd, exp_wr;
  bit            pend_rd, pend_wr;
  bit            last_rw;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_d;
  bit            prev_v, prev_hs;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            rr_mode = 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // cycle count and reference reset
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      pend_rd = 1'b0;
      pend_wr = 1'b0;
      exp_rd  = '0;
      exp_wr  = '0;
      prev_v  = 1'b0;
      prev_hs = 1'b0;
      last_rw = 1'b1;
      last_a  = '0;
      last_d  = '0;
      for (int i = 0; i < 8; i++) ref_mem[i] = '1;
    end
  end

  // response consumer
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // monitor: compares every cycle against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (pend_rd) exp_rd = exp_rd + 1'b1;
      if (pend_wr) exp_wr = exp_wr + 1'b1;
      pend_rd = 1'b0;
      pend_wr = 1'b0;
      chk("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
      chk("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
      chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
      chk("mem_enable", 32'(mem_enable),
          32'(q.size() != 0 && cyc == q[0].acc));
      chk("mem_rd_wr", 32'(mem_rd_wr), 32'(last_rw));
      chk("mem_addr", 32'(mem_addr), 32'(last_a));
      chk("mem_wr_data", 32'(mem_wr_data), 32'(last_d));
      if (prev_v && !prev_hs) chk("rsp_hold", 32'(rsp_valid), 32'd1);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_spurious", 32'(rsp_valid), 32'd0);
        end else begin
          if (!prev_v || prev_hs)
            chk("rsp_latency", 32'(cyc - q[0].acc),
                32'(q[0].w ? 1 : 1 + LAT));
          chk("rsp_write", 32'(rsp_write), 32'(q[0].w));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(q[0].rd));
          if (rsp_ready) begin
            if (q[0].w) pend_wr = 1'b1;
            else pend_rd = 1'b1;
            void'(q.pop_front());
          end
        end
      end
      prev_v  = rsp_valid;
      prev_hs = rsp_valid && rsp_ready;
    end
  end

  // issue one command; expected response pushed at acceptance
  task automatic do_req(input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int   t;
    txn_t x;
    t = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (req_ready !== 1'b1) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    if (!rst) begin
      #1;
      x.w   = w;
      x.a   = a;
      x.acc = cyc;
      if (w) begin
        ref_mem[a] = d;
        x.rd = '0;
      end else begin
        x.rd = ref_mem[a];
      end
      last_rw = !w;
      last_a  = a;
      last_d  = w ? d : '0;
      q.push_back(x);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rr_mode = 1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_enable", 32'(mem_enable), 32'd0);
    chk("rst_mem_rd_wr", 32'(mem_rd_wr), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_write", 32'(rsp_write), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);

    do_req(1'b0, 3'd7, 8'h00);
    wait_drain();
    do_req(1'b1, 3'd3, 8'hA5);
    wait_drain();
    do_req(1'b0, 3'd3, 8'h00);
    wait_drain();

    rr_mode = 2;
    do_req(1'b0, 3'd3, 8'h00);
    t = 0;
    while (rsp_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd3;
    req_wdata = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rr_mode = 1;
    wait_drain();
    repeat (2) @(negedge clk);
    chk("bp_rd_cnt", 32'(rd_cnt), 32'd3);

    @(posedge clk);
    #2;
    rst = 1'b1;
    do_req(1'b1, 3'd1, 8'h5A);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    do_req(1'b1, 3'd2, 8'h77);
    wait_drain();
    do_req(1'b0, 3'd2, 8'h00);
    do_reset(1);
    repeat (6) @(negedge clk);
    chk("midwait_rd_cnt", 32'(rd_cnt), 32'd0);
    do_req(1'b0, 3'd2, 8'h00);
    wait_drain();

    rr_mode = 0;
    for (int i = 0; i < 200; i++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rr_mode = 1;
    wait_drain();
    repeat (2) @(negedge clk);

    @(posedge clk);
    #2;
    force dut.wr_cnt_q = 16'hFFFF;
    exp_wr = 16'hFFFF;
    @(posedge clk);
    #2;
    release dut.wr_cnt_q;
    @(negedge clk);
    do_req(1'b1, 3'd4, 8'h99);
    wait_drain();
    repeat (2) @(negedge clk);
    chk("wr_cnt_wrap", 32'(wr_cnt), 32'd0);

    chk("final_queue", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
